tbb: RTL and testbench
======================

// Module: tbb
// PURPOSE
//  Task batch buffer: input-side counterpart of the result batch buffer. On batch_start it
//  issues line read requests (0..NUM_LINES-1) to the host read path. It writes the returned
//  lines, which may arrive out of order, into a simple dual-port BRAM. Once every line has
//  arrived it presents the batch to one PE array for random-access reads until released.
// PARAMETERS
//  TBB_ADDR_WIDTH  8    line index width; NUM_LINES = 1<<TBB_ADDR_WIDTH
//  TBB_DATA_WIDTH  512  line width in bits (one cache line)
// PORTS
//  clk          in   1     core clock; all logic on posedge
//  reset        in   1     synchronous, active-high
//  batch_start  in   1     pulse: begin filling a new batch (honoured only in IDLE)
//  ReqValid     out  1     line read request pending
//  ReqLineIdx   out  AW    line index of pending request
//  ReqAck       in   1     host accepted current request (meaningful only with ReqValid)
//  RspValid     in   1     returned line valid this cycle
//  RspLineIdx   in   AW    index of returned line
//  RspData      in   DW    returned line data
//  Full         out  1     complete batch resident; PE may read
//  Empty        out  1     no batch in progress or resident (IDLE)
//  RdAddr       in   AW    PE read address
//  RdDout       out  DW    PE read data, 1 cycle after RdAddr
//  task_release in   1     pulse: PE finished with batch (honoured only in FULL)
//  Error        out  1     sticky protocol error flag, cleared only by reset
// BEHAVIOUR
//  States (one-hot): IDLE, FILL, FULL.
//  Counters: req_cnt [AW:0] = requests accepted; rsp_cnt [AW:0] = responses written.
//  Reset: state=IDLE, req_cnt=rsp_cnt=0, ReqValid=0, ReqLineIdx=0, Full=0, Empty=1,
//   Error=0, RdDout=0. BRAM contents are not cleared.
//  IDLE: Empty=1. If batch_start, then next=FILL and req_cnt, rsp_cnt <= 0.
//  FILL: ReqValid = (req_cnt < NUM_LINES); ReqLineIdx = req_cnt[AW-1:0].
//   - Valid/idx held stable until ReqAck; ReqAck increments req_cnt (no wrap; stops at NUM_LINES).
//   - Request k is visible the cycle after request k-1 is acked: at most 1 request/cycle,
//     no bubbles. ReqAck with ReqValid=0 is ignored.
//   - RspValid writes RspData to BRAM[RspLineIdx] at that edge and increments rsp_cnt.
//   - Responses may overlap requests, arrive in any order, and coincide with ReqAck;
//     both counters update in the same cycle.
//   - A response in the cycle where rsp_cnt==NUM_LINES-1 gives next=FULL.
//     Full=1 on the following cycle (fill-done latency 1).
//   - A response with rsp_cnt already >= req_cnt (more responses than accepted requests)
//     sets Error. The data is still written but not counted.
//  FULL: Full=1, ReqValid=0. If task_release, then next=IDLE (Full=0, Empty=1 next cycle).
//  PE read port: RdDout <= BRAM[RdAddr] on every edge, in every state (registered, latency 1).
//   - Data is guaranteed valid only for reads issued while Full=1.
//  Write-then-read: a line written at edge N is returned by a read issued at cycle N+1.
//  Ignored events: batch_start outside IDLE; task_release outside FULL.
//   - RspValid in IDLE or FULL is dropped (no BRAM write) and sets Error.
//  Reset mid-FILL or mid-FULL: immediately IDLE. In-flight host responses arriving after
//   reset are dropped and flag Error.
// TESTING (TBB_ADDR_WIDTH=2, NUM_LINES=4)
//  1 batch_start, ReqAck held 1, in-order rsp idx 0..3 data 'hA0..'hA3
//    -> ReqLineIdx 0,1,2,3 on consecutive cycles; Full=1 one cycle after rsp 3;
//       RdAddr=2 -> RdDout='hA2 next cycle.
//  2 ReqAck toggling 1,0,1,0 -> ReqLineIdx holds during non-ack cycles;
//    exactly 4 acks; ReqValid=0 after 4th.
//  3 Responses in order 3,1,0,2, one overlapping the last ReqAck
//    -> Full only after the 4th response; all 4 lines read back correctly.
//  4 In FULL: pulse batch_start, then task_release
//    -> batch_start ignored; Empty=1 next cycle after release; second batch refills cleanly.
//  5 RspValid while IDLE, or a 2nd response when req_cnt==1, rsp_cnt==1
//    -> Error=1 and stays 1; rsp_cnt unchanged.
//  6 Reset asserted after 2 responses in FILL
//    -> IDLE, ReqValid=0, Full=0, Empty=1 next cycle; fresh batch completes normally.

Source files
------------

// File: rtl/tbb.sv
// Task batch buffer: requests lines 0..NUM_LINES-1, stores out-of-order returns, then serves PE reads.
// Requests held until ReqAck (1/cycle); Full one cycle after last response; RdDout registered, latency 1.
module tbb #(
  parameter int TBB_ADDR_WIDTH = 8,
  parameter int TBB_DATA_WIDTH = 512
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      batch_start,
  output logic                      ReqValid,
  output logic [TBB_ADDR_WIDTH-1:0] ReqLineIdx,
  input  logic                      ReqAck,
  input  logic                      RspValid,
  input  logic [TBB_ADDR_WIDTH-1:0] RspLineIdx,
  input  logic [TBB_DATA_WIDTH-1:0] RspData,
  output logic                      Full,
  output logic                      Empty,
  input  logic [TBB_ADDR_WIDTH-1:0] RdAddr,
  output logic [TBB_DATA_WIDTH-1:0] RdDout,
  input  logic                      task_release,
  output logic                      Error
);

  localparam int NUM_LINES = 1 << TBB_ADDR_WIDTH;
  localparam logic [TBB_ADDR_WIDTH:0] LAST_CNT = (TBB_ADDR_WIDTH+1)'(NUM_LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_FILL = 3'b010,
    S_FULL = 3'b100
  } state_t;

  state_t                    r_state;
  logic [TBB_ADDR_WIDTH:0]   r_req_cnt;
  logic [TBB_ADDR_WIDTH:0]   r_rsp_cnt;
  logic                      r_error;
  logic [TBB_DATA_WIDTH-1:0] r_mem [NUM_LINES];

  logic w_in_fill;
  logic w_req_fire;
  logic w_rsp_ok;
  logic w_mem_we;

  assign w_in_fill  = (r_state == S_FILL);
  assign ReqValid   = w_in_fill && !r_req_cnt[TBB_ADDR_WIDTH];
  assign ReqLineIdx = r_req_cnt[TBB_ADDR_WIDTH-1:0];
  assign w_req_fire = ReqValid && ReqAck;
  // A response is only counted if it matches an already accepted request.
  assign w_rsp_ok   = RspValid && (r_rsp_cnt < r_req_cnt);
  assign w_mem_we   = RspValid && w_in_fill;
  assign Full       = (r_state == S_FULL);
  assign Empty      = (r_state == S_IDLE);
  assign Error      = r_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_req_cnt <= '0;
      r_rsp_cnt <= '0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (RspValid) r_error <= 1'b1;
          if (batch_start) begin
            r_state   <= S_FILL;
            r_req_cnt <= '0;
            r_rsp_cnt <= '0;
          end
        end
        S_FILL: begin
          if (w_req_fire) r_req_cnt <= r_req_cnt + 1'b1;
          if (w_rsp_ok) begin
            r_rsp_cnt <= r_rsp_cnt + 1'b1;
            if (r_rsp_cnt == LAST_CNT) r_state <= S_FULL;
          end else if (RspValid) begin
            r_error <= 1'b1;
          end
        end
        S_FULL: begin
          if (RspValid) r_error <= 1'b1;
          if (task_release) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[RspLineIdx] <= RspData;
  end

  // Read-first: a same-edge write becomes visible to the following read.
  always_ff @(posedge clk) begin
    if (reset) RdDout <= '0;
    else       RdDout <= r_mem[RdAddr];
  end

endmodule

// File: tb/tb_tbb.sv
// Randomized bench for tbb (4 lines x 32 bits) against a behavioural batch model.
module tb_tbb;
  localparam int AW = 2;
  localparam int DW = 32;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          bs = 1'b0;
  logic          req_vld;
  logic [AW-1:0] req_idx;
  logic          ack = 1'b0;
  logic          rv = 1'b0;
  logic [AW-1:0] ridx = '0;
  logic [DW-1:0] rdat = '0;
  logic          full;
  logic          empty;
  logic [AW-1:0] rdaddr = '0;
  logic [DW-1:0] rddout;
  logic          rel = 1'b0;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: batch phase, accepted requests, counted responses, sticky error, line store.
  typedef enum int {P_IDLE, P_FILL, P_FULL} phase_t;
  phase_t        m_phase = P_IDLE;
  int            m_acked = 0;
  int            m_got   = 0;
  bit            m_err   = 1'b0;
  logic [DW-1:0] m_mem [N];
  int            pend [$];

  tbb #(.TBB_ADDR_WIDTH(AW), .TBB_DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(rst), .batch_start(bs),
    .ReqValid(req_vld), .ReqLineIdx(req_idx), .ReqAck(ack),
    .RspValid(rv), .RspLineIdx(ridx), .RspData(rdat),
    .Full(full), .Empty(empty), .RdAddr(rdaddr), .RdDout(rddout),
    .task_release(rel), .Error(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge: advance the model with the current inputs, then compare outputs.
  task automatic cyc();
    bit            rd_chk;
    logic [DW-1:0] rd_exp;
    int            acked_before;
    rd_chk = (m_phase == P_FULL) && !rst;
    rd_exp = m_mem[rdaddr];
    acked_before = m_acked;
    if (rst) begin
      m_phase = P_IDLE; m_acked = 0; m_got = 0; m_err = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          if (rv) m_err = 1'b1;
          if (bs) begin m_phase = P_FILL; m_acked = 0; m_got = 0; end
        end
        P_FILL: begin
          if (ack && m_acked < N) m_acked++;
          if (rv) begin
            m_mem[ridx] = rdat;
            if (m_got >= acked_before) m_err = 1'b1;
            else begin
              m_got++;
              if (m_got == N) m_phase = P_FULL;
            end
          end
        end
        default: begin
          if (rv) m_err = 1'b1;
          if (rel) m_phase = P_IDLE;
        end
      endcase
    end
    @(posedge clk);
    #1;
    chk("ReqValid", 64'(req_vld), 64'(m_phase == P_FILL && m_acked < N));
    if (m_phase == P_FILL && m_acked < N) chk("ReqLineIdx", 64'(req_idx), 64'(m_acked));
    chk("Full", 64'(full), 64'(m_phase == P_FULL));
    chk("Empty", 64'(empty), 64'(m_phase == P_IDLE));
    chk("Error", 64'(err), 64'(m_err));
    if (rst)    chk("RdDout_reset", 64'(rddout), 64'd0);
    if (rd_chk) chk("RdDout", 64'(rddout), 64'(rd_exp));
  endtask

  task automatic do_reset();
    rst = 1'b1; bs = 1'b0; ack = 1'b0; rv = 1'b0; rel = 1'b0;
    cyc();
    rst = 1'b0;
    pend.delete();
  endtask

  // Host side: random ack rate, random-order responses to accepted requests.
  task automatic fill(input int ack_pct, input int rsp_pct, input bit seq_data);
    int k;
    int acc_idx;
    bit will_acc;
    for (int t = 0; t < 200 && m_phase == P_FILL; t++) begin
      ack = ($urandom_range(0, 99) < ack_pct);
      will_acc = ack && m_acked < N;
      acc_idx = m_acked;
      if (pend.size() > 0 && $urandom_range(0, 99) < rsp_pct) begin
        k = $urandom_range(0, pend.size() - 1);
        rv = 1'b1;
        ridx = AW'(pend[k]);
        rdat = seq_data ? DW'(32'hA0 + pend[k]) : DW'($urandom);
        pend.delete(k);
      end else rv = 1'b0;
      cyc();
      if (will_acc) pend.push_back(acc_idx);
      rdaddr = AW'($urandom_range(0, N - 1));
    end
    ack = 1'b0; rv = 1'b0;
    chk("fill_done", 64'(full), 64'd1);
  endtask

  task automatic run_batch(input int ack_pct, input int rsp_pct, input bit seq_data);
    bs = 1'b1; cyc(); bs = 1'b0;
    fill(ack_pct, rsp_pct, seq_data);
    for (int i = 0; i < N; i++) begin rdaddr = AW'(i); cyc(); end
    for (int i = 0; i < 3; i++) begin rdaddr = AW'($urandom_range(0, N - 1)); cyc(); end
    bs = 1'b1; cyc(); bs = 1'b0;          // ignored while full
    rel = 1'b1; cyc(); rel = 1'b0;
    cyc();
  endtask

  initial begin
    do_reset();
    chk("ReqLineIdx_reset", 64'(req_idx), 64'd0);
    cyc();
    run_batch(100, 100, 1'b1);            // in-order, back-to-back
    run_batch(50, 100, 1'b0);             // toggling ack
    run_batch(100, 30, 1'b0);             // out-of-order responses
    for (int b = 0; b < 6; b++)
      run_batch($urandom_range(30, 100), $urandom_range(20, 100), 1'b0);

    rv = 1'b1; ridx = 2'd1; rdat = DW'($urandom); cyc(); rv = 1'b0;   // response while idle
    cyc();
    bs = 1'b1; cyc(); bs = 1'b0;
    ack = 1'b1; cyc(); ack = 1'b0;
    rv = 1'b1; ridx = 2'd0; rdat = DW'($urandom); cyc();
    rv = 1'b1; ridx = 2'd0; rdat = DW'($urandom); cyc(); rv = 1'b0;  // excess response
    pend.delete();
    fill(100, 100, 1'b0);                 // rest of batch still completes
    rel = 1'b1; cyc(); rel = 1'b0;

    do_reset();
    bs = 1'b1; cyc(); bs = 1'b0;
    ack = 1'b1; cyc(); cyc(); ack = 1'b0;
    rv = 1'b1; ridx = 2'd1; rdat = DW'($urandom); cyc();
    rv = 1'b1; ridx = 2'd0; rdat = DW'($urandom); cyc(); rv = 1'b0;
    do_reset();
    rv = 1'b1; ridx = 2'd2; rdat = DW'($urandom); cyc(); rv = 1'b0;  // in-flight after reset
    do_reset();
    run_batch(70, 60, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
